// File: rtl/sseg_pkg.sv
// Shared types and constants for the ElbertV2 multiplexed seven-segment controller.
package sseg_pkg;

    localparam int unsigned DIGITS = 3;

    typedef enum logic {GAP, ON} state_e;

    localparam logic [7:0]        SEG_OFF = 8'hFF;
    localparam logic [DIGITS-1:0] EN_OFF  = 3'b111;

    // Active-high gfedcba patterns for hex digits 0..F; index with the nibble value.
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot sequencer: GAP/ON FSM, slot cycle counter, PWM phase, digit index and frame tick.
// Next-state values are exported so the top can register outputs aligned with the FSM.
module sseg_slot_timer import sseg_pkg::*; #(
    parameter int unsigned SCAN_DIV = 4000,
    parameter int unsigned GAP_CYC  = 16
) (
    input  logic       clk,
    input  logic       reset,
    output state_e     state_next,
    output logic [2:0] phase_next,
    output logic [1:0] idx,
    output logic       slot_start,
    output logic       frame_tick
);

    localparam int unsigned PHASE_LEN = SCAN_DIV / 8;
    localparam int unsigned MAXV      = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int unsigned CW        = $clog2(MAXV + 1);
    localparam int unsigned SW        = $clog2(PHASE_LEN + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sub_q, sub_d;
    logic [2:0]      phase_q, phase_d;
    logic [1:0]      idx_q, idx_d;
    logic            tick;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        sub_d   = sub_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        tick    = 1'b0;
        case (state_q)
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = ON;
                    cnt_d   = '0;
                    sub_d   = '0;
                    phase_d = '0;
                end
            end
            ON: begin
                if (sub_q == SW'(PHASE_LEN - 1)) begin
                    sub_d   = '0;
                    phase_d = phase_q + 3'd1;
                end else begin
                    sub_d = sub_q + SW'(1);
                end
                if (cnt_q == CW'(SCAN_DIV - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    idx_d   = (idx_q == 2'(DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
                    tick    = (idx_q == 2'(DIGITS - 1));
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GAP;
            cnt_q   <= '0;
            sub_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    assign state_next = state_d;
    assign phase_next = phase_d;
    assign idx        = idx_q;
    assign slot_start = (state_q == GAP) && (cnt_q == '0);
    assign frame_tick = tick;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Three-digit seven-segment refresh controller with shadowed writes, PWM dimming and blink.
// Outputs are registered from the timer's next state so ss/en line up with GAP/ON slots.
module sseg_scan_ctrl import sseg_pkg::*; #(
    parameter int unsigned SCAN_DIV     = 4000,
    parameter int unsigned GAP_CYC      = 16,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              wr_blink,
    input  logic [2:0]        brightness,
    input  logic              blank,
    output logic              frame_tick,
    output logic [7:0]        ss,
    output logic [DIGITS-1:0] en
);

    localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

    state_e     state_next;
    logic [2:0] phase_next;
    logic [1:0] idx;
    logic       slot_start;
    logic       tick_raw;

    sseg_slot_timer #(
        .SCAN_DIV (SCAN_DIV),
        .GAP_CYC  (GAP_CYC)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .state_next (state_next),
        .phase_next (phase_next),
        .idx        (idx),
        .slot_start (slot_start),
        .frame_tick (tick_raw)
    );

    logic [DIGITS-1:0][7:0] shadow_pat_q, active_pat_q;
    logic [DIGITS-1:0]      shadow_blink_q, active_blink_q;
    logic [2:0]             bright_q, bright_d;
    logic                   blank_q, blank_d;
    logic [FW-1:0]          frame_cnt_q;
    logic                   blink_phase_q;
    logic [7:0]             ss_q, ss_d;
    logic [DIGITS-1:0]      en_q, en_d;
    logic                   wr_fire;

    // Commits happen on the tick cycle, so writes are refused there.
    assign wr_ready   = ~reset & ~tick_raw;
    assign frame_tick = ~reset & tick_raw;
    assign wr_fire    = wr_valid & wr_ready;

    // Forward the slot-start sample so a one-cycle gap still sees the new settings.
    assign bright_d = slot_start ? brightness : bright_q;
    assign blank_d  = slot_start ? blank : blank_q;

    always_comb begin
        ss_d = SEG_OFF;
        en_d = EN_OFF;
        if (state_next == ON) begin
            ss_d = ~active_pat_q[idx];
            if ((phase_next <= bright_d) && !blank_d &&
                !(blink_phase_q && active_blink_q[idx])) begin
                en_d[idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_pat_q   <= '0;
            active_pat_q   <= '0;
            shadow_blink_q <= '0;
            active_blink_q <= '0;
            bright_q       <= '0;
            blank_q        <= 1'b0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            ss_q           <= SEG_OFF;
            en_q           <= EN_OFF;
        end else begin
            bright_q <= bright_d;
            blank_q  <= blank_d;
            ss_q     <= ss_d;
            en_q     <= en_d;
            if (tick_raw) begin
                active_pat_q   <= shadow_pat_q;
                active_blink_q <= shadow_blink_q;
                if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FW'(1);
                end
            end
            // Address 3 matches no digit and is silently dropped.
            for (int i = 0; i < DIGITS; i++) begin
                if (wr_fire && (wr_addr == 2'(i))) begin
                    shadow_pat_q[i]   <= wr_data;
                    shadow_blink_q[i] <= wr_blink;
                end
            end
        end
    end

    assign ss = ss_q;
    assign en = en_q;

endmodule
